dma_ram_responder: RTL and testbench
====================================

// Module: dma_ram_responder
// PURPOSE
//  RAM-side consumer of the DMA command stream: valid, End, 64-bit RAM address, 2-bit trans.
//  Buffers beats in a small FIFO and issues one memory request per beat.
//  Tracks burst boundaries and pulses done when a burst has fully drained to memory.
//  Sits between the DMA signal register stage and the RAM model/controller.
// PARAMETERS
//  ADDR_W     64  width of addr_IN / mem_addr_OUT
//  DEPTH      4   FIFO entries; power of 2, >= 2
//  CNT_W      16  width of beat_cnt_OUT
//  ADDR_STEP  8   expected address increment per beat (used only with ADDR_CHECK_EN)
// PORTS
//  clk           in   1       rising-edge clock
//  reset_L       in   1       synchronous, active-low reset
//  valid_IN      in   1       beat present this cycle
//  End_IN        in   1       last beat of burst (alone in BURST: terminate, no data)
//  addr_IN       in   ADDR_W  RAM address of beat
//  trans_IN      in   2       00 none, 01 read, 10 write, 11 illegal
//  mem_ready_IN  in   1       memory accepts current request at this edge
//  ready_OUT     out  1       advisory: FIFO not full and state IDLE/BURST
//  mem_req_OUT   out  1       request valid
//  mem_we_OUT    out  1       1 = write, 0 = read
//  mem_addr_OUT  out  ADDR_W  request address
//  done_OUT      out  1       one-cycle pulse, burst complete
//  beat_cnt_OUT  out  CNT_W   beats accepted in current/last burst
//  err_OUT       out  4       sticky: [0] illegal trans, [1] drop/overflow, [2] trans mismatch, [3] addr seq
// BEHAVIOUR
//  Reset (reset_L==0 at edge): all outputs 0, FIFO empty, state IDLE; aborts any burst, no done.
//  States: IDLE, BURST, DRAIN, DONE.
//   IDLE : valid_IN & trans!=11 & trans!=00 -> accept beat, latch burst trans, beat_cnt=1;
//          End_IN on the same beat -> DRAIN, else -> BURST. Lone End_IN is ignored.
//   BURST: valid_IN & End_IN -> accept beat, -> DRAIN. ~valid_IN & End_IN -> DRAIN.
//   DRAIN: FIFO empty & no pending request -> DONE.
//   DONE : done_OUT=1 for this cycle only; -> IDLE.
//  Accept: push at the edge iff FIFO not full at that edge (a same-cycle pop does not free a slot).
//  Drop: valid_IN while full, or while in DRAIN/DONE -> beat discarded, err[1] set.
//  trans 11 -> beat discarded, err[0] set (End on it still honoured in BURST).
//  trans 00 with valid_IN -> beat discarded silently.
//  Beat trans != latched trans -> beat accepted with latched trans, err[2] set.
//  beat_cnt_OUT: +1 per accepted beat, saturates at 2^CNT_W-1, holds after DONE until the next burst starts.
//  Memory side: mem_req_OUT/mem_we_OUT/mem_addr_OUT registered from FIFO head.
//  Earliest mem_req_OUT is 1 cycle after push.
//  Request held stable until mem_req_OUT & mem_ready_IN at an edge.
//  Pop at that edge; next head presented the following cycle (back-to-back allowed).
//  mem_we_OUT = 1 iff latched trans == 10.
//  FIFO pointers: log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty from MSB compare.
//  err_OUT is sticky; cleared only by reset.
// CONFIGURATION
//  ADDR_CHECK_EN defined:
//   each accepted beat after the first in a burst must have addr == previous accepted addr + ADDR_STEP
//   (ADDR_W-bit wrap); mismatch sets err[3], beat still accepted.
//  ADDR_CHECK_EN undefined: no checker logic; err_OUT[3] tied 0.
// TESTING
//  Reset: hold reset_L=0 2 cycles mid-burst -> all outputs 0, no done_OUT, next burst beat_cnt_OUT starts at 1.
//  Write burst:
//   4 beats trans=10, addr 0x100,0x108,0x110,0x118 (End on 4th), mem_ready_IN=1
//   -> 4 reqs we=1 in order, done_OUT 1 cycle, beat_cnt_OUT=4, err_OUT=0.
//  Backpressure: DEPTH=4, mem_ready_IN=0, 6 beats trans=01
//   -> ready_OUT=0 after 4, err[1]=1, release -> exactly 4 reqs we=0, then done_OUT.
//  Illegal/mismatch: beats trans=01,11,10 (End on last)
//   -> err[0]=1, err[2]=1, 2 reqs both we=0, beat_cnt_OUT=2.
//  Lone End: End_IN=1 valid_IN=0 in IDLE -> no state change, no done.
//   Same in BURST after 1 beat -> done after drain, beat_cnt_OUT=1.
//  ADDR_CHECK_EN: addrs 0x0,0x8,0x20 -> err[3]=1, 3 reqs issued; without macro err[3]=0.

Source files
------------

// File: rtl/dma_ram_responder.sv
// RAM-side DMA command consumer: FIFO-buffers beats, issues one memory request per beat, pulses done per burst.
// Optional ADDR_CHECK_EN enables the per-burst address-sequence checker (err_OUT[3]).
module dma_ram_responder #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_IN,
    input  logic              End_IN,
    input  logic [ADDR_W-1:0] addr_IN,
    input  logic [1:0]        trans_IN,
    input  logic              mem_ready_IN,
    output logic              ready_OUT,
    output logic              mem_req_OUT,
    output logic              mem_we_OUT,
    output logic [ADDR_W-1:0] mem_addr_OUT,
    output logic              done_OUT,
    output logic [CNT_W-1:0]  beat_cnt_OUT,
    output logic [3:0]        err_OUT
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_STEP == 0) begin : g_bad_params
        $error("dma_ram_responder: DEPTH must be a power of 2 >= 2 and ADDR_STEP nonzero");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [1:0]         trans_q, trans_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         err_q, err_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ready_q, ready_d;
    logic [ADDR_W-1:0]  mem_q [DEPTH];
`ifdef ADDR_CHECK_EN
    logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
`endif

    logic               beat_legal;
    logic               fifo_full;
    logic               fifo_empty;
    logic               full_d;
    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   remain;

    assign beat_legal = valid_IN && (trans_IN == 2'b01 || trans_IN == 2'b10);
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                        (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
    assign pop        = req_q && mem_ready_IN;

    always_comb begin
        state_d = state_q;
        trans_d = trans_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push    = 1'b0;
`ifdef ADDR_CHECK_EN
        last_addr_d = last_addr_q;
`endif

        if (valid_IN && trans_IN == 2'b11) begin
            err_d[0] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (beat_legal) begin
                    push    = 1'b1;
                    trans_d = trans_IN;
                    cnt_d   = CNT_W'(1);
`ifdef ADDR_CHECK_EN
                    last_addr_d = addr_IN;
`endif
                    state_d = End_IN ? DRAIN : BURST;
                end
            end
            BURST: begin
                if (beat_legal) begin
                    if (fifo_full) begin
                        err_d[1] = 1'b1;
                    end else begin
                        push  = 1'b1;
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                        if (trans_IN != trans_q) begin
                            err_d[2] = 1'b1;
                        end
`ifdef ADDR_CHECK_EN
                        if (addr_IN != last_addr_q + ADDR_W'(ADDR_STEP)) begin
                            err_d[3] = 1'b1;
                        end
                        last_addr_d = addr_IN;
`endif
                    end
                end
                // End terminates the burst even when its beat is dropped or illegal
                if (End_IN) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_legal) begin
                    err_d[1] = 1'b1;
                end
                if (fifo_empty && !req_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (beat_legal) begin
                    err_d[1] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifndef ADDR_CHECK_EN
        err_d[3] = 1'b0;
`endif
    end

    // The request register presents the entry at rd_q; rd_q only advances on the handshake,
    // so the presented beat still occupies its FIFO slot until memory takes it.
    always_comb begin
        wr_d   = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d   = pop  ? rd_q + PTR_W'(1) : rd_q;
        remain = (wr_q - rd_q) - PTR_W'(pop);
        req_d  = (remain != '0);
        we_d   = we_q;
        addr_d = addr_q;
        if (req_d) begin
            addr_d = mem_q[rd_d[IDX_W-1:0]];
            we_d   = (trans_q == 2'b10);
        end
        full_d  = (wr_d[PTR_W-1] != rd_d[PTR_W-1]) &&
                  (wr_d[IDX_W-1:0] == rd_d[IDX_W-1:0]);
        ready_d = !full_d && (state_d == IDLE || state_d == BURST);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            trans_q <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ready_q <= 1'b0;
`ifdef ADDR_CHECK_EN
            last_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            trans_q <= trans_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
`ifdef ADDR_CHECK_EN
            last_addr_q <= last_addr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset_L && push) begin
            mem_q[wr_q[IDX_W-1:0]] <= addr_IN;
        end
    end

    assign ready_OUT    = ready_q;
    assign mem_req_OUT  = req_q;
    assign mem_we_OUT   = we_q;
    assign mem_addr_OUT = addr_q;
    assign done_OUT     = (state_q == DONE);
    assign beat_cnt_OUT = cnt_q;
    assign err_OUT      = err_q;

endmodule

// File: tb/tb_dma_ram_responder.sv
// Scoreboard bench for dma_ram_responder: driver feeds beats and a burst-level model,
// monitor pops expected memory requests and done pulses as the DUT presents them.
module tb_dma_ram_responder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        valid_IN = 1'b0;
    logic        End_IN = 1'b0;
    logic [63:0] addr_IN = '0;
    logic [1:0]  trans_IN = '0;
    logic        mem_ready_IN = 1'b0;
    logic        ready_OUT;
    logic        mem_req_OUT;
    logic        mem_we_OUT;
    logic [63:0] mem_addr_OUT;
    logic        done_OUT;
    logic [15:0] beat_cnt_OUT;
    logic [3:0]  err_OUT;

    always #5 clk = ~clk;

    dma_ram_responder #(
        .ADDR_W(64),
        .DEPTH(DEPTH),
        .CNT_W(16),
        .ADDR_STEP(8)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .valid_IN(valid_IN),
        .End_IN(End_IN),
        .addr_IN(addr_IN),
        .trans_IN(trans_IN),
        .mem_ready_IN(mem_ready_IN),
        .ready_OUT(ready_OUT),
        .mem_req_OUT(mem_req_OUT),
        .mem_we_OUT(mem_we_OUT),
        .mem_addr_OUT(mem_addr_OUT),
        .done_OUT(done_OUT),
        .beat_cnt_OUT(beat_cnt_OUT),
        .err_OUT(err_OUT)
    );

    typedef struct {
        logic [63:0] addr;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int pops_total = 0;
    int pops_snap = 0;
    int pushes = 0;
    int done_seen = 0;
    int ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
    bit pop_pending = 1'b0;
    bit expect_done = 1'b0;

    // burst-level reference state
    bit          in_burst = 1'b0;
    logic [1:0]  b_trans = '0;
    logic [15:0] m_cnt = '0;
    logic [63:0] m_last = '0;
    logic [3:0]  m_err = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       mem_ready_IN = ($urandom_range(0, 3) != 0);
                1:       mem_ready_IN = 1'b1;
                default: mem_ready_IN = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            pop_pending = 1'b0;
            if (reset_L && mem_req_OUT && mem_ready_IN) begin
                pop_pending = 1'b1;
                pops_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected actual_addr=0x%0h required=none", mem_addr_OUT);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("req_addr", mem_addr_OUT, mon_e.addr);
                    check("req_we", 64'(mem_we_OUT), 64'(mon_e.we));
                end
            end
            if (done_OUT) begin
                checks++;
                if (!expect_done) begin
                    errors++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end
                expect_done = 1'b0;
                done_seen++;
            end
        end
    end

    task automatic push_exp();
        exp_q.push_back('{addr: addr_IN, we: (b_trans == 2'b10)});
        pushes++;
    endtask

    // Evaluated at each active edge with the inputs the DUT samples there.
    task automatic model_edge();
        int occ;
        bit legal;
        if (!reset_L) begin
            in_burst    = 1'b0;
            m_cnt       = '0;
            m_err       = '0;
            pushes      = 0;
            pops_snap   = pops_total;
            expect_done = 1'b0;
            exp_q.delete();
            return;
        end
        occ   = pushes - (pops_total - pops_snap - int'(pop_pending));
        legal = valid_IN && (trans_IN == 2'b01 || trans_IN == 2'b10);
        if (valid_IN && trans_IN == 2'b11) m_err[0] = 1'b1;
        if (legal && !in_burst) begin
            b_trans  = trans_IN;
            m_cnt    = 16'd1;
            m_last   = addr_IN;
            in_burst = 1'b1;
            push_exp();
        end else if (legal && in_burst) begin
            if (occ >= DEPTH) begin
                m_err[1] = 1'b1;
            end else begin
                if (trans_IN != b_trans) m_err[2] = 1'b1;
`ifdef ADDR_CHECK_EN
                if (addr_IN != m_last + 64'd8) m_err[3] = 1'b1;
`endif
                m_last = addr_IN;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                push_exp();
            end
        end
        if (in_burst && End_IN) begin
            in_burst    = 1'b0;
            expect_done = 1'b1;
        end
    endtask

    task automatic cycle(input logic v, input logic e, input logic [63:0] a, input logic [1:0] t);
        valid_IN = v;
        End_IN   = e;
        addr_IN  = a;
        trans_IN = t;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 64'd0, 2'b00);
    endtask

    task automatic finish_burst(input string tag);
        int start;
        bit got;
        start = done_seen;
        got   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_seen != start) begin
                got = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0, 64'd0, 2'b00);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done_timeout actual=no_done required=done", tag);
        end
        check({tag, "_cnt"}, 64'(beat_cnt_OUT), 64'(m_cnt));
        check({tag, "_err"}, 64'(err_OUT), 64'(m_err));
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 64'(ready_OUT), 64'd0);
        check({tag, "_req"}, 64'(mem_req_OUT), 64'd0);
        check({tag, "_we"}, 64'(mem_we_OUT), 64'd0);
        check({tag, "_addr"}, mem_addr_OUT, 64'd0);
        check({tag, "_done"}, 64'(done_OUT), 64'd0);
        check({tag, "_cnt"}, 64'(beat_cnt_OUT), 64'd0);
        check({tag, "_err"}, 64'(err_OUT), 64'd0);
    endtask

    initial begin
        logic [63:0] base;
        logic [63:0] a;
        logic [1:0]  bt;
        logic [1:0]  t;
        int          len;
        int          r;

        reset_L = 1'b0;
        idle(3);
        check_zero("reset");
        reset_L = 1'b1;
        idle(1);

        // write burst, memory always ready
        ready_mode = 1;
        idle(2);
        for (int i = 0; i < 4; i++) cycle(1'b1, (i == 3), 64'h100 + 64'(8 * i), 2'b10);
        finish_burst("wr");
        check("wr_err_zero", 64'(err_OUT), 64'd0);

        // lone End in IDLE is ignored
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 64'd0, 2'b00);
        idle(2);
        check("lone_idle_ready", 64'(ready_OUT), 64'd1);
        check("lone_idle_cnt", 64'(beat_cnt_OUT), 64'd4);
        cycle(1'b1, 1'b0, 64'h40, 2'b01);
        idle(2);
        cycle(1'b0, 1'b1, 64'd0, 2'b00);
        finish_burst("lone_burst");
        check("lone_burst_cnt1", 64'(beat_cnt_OUT), 64'd1);

        // address sequence 0x0,0x8,0x20
        cycle(1'b1, 1'b0, 64'h0, 2'b10);
        cycle(1'b1, 1'b0, 64'h8, 2'b10);
        cycle(1'b1, 1'b1, 64'h20, 2'b10);
        finish_burst("addr");
`ifdef ADDR_CHECK_EN
        check("addr_err3", 64'(err_OUT[3]), 64'd1);
`else
        check("addr_err3", 64'(err_OUT[3]), 64'd0);
`endif

        // illegal and mismatched trans
        cycle(1'b1, 1'b0, 64'h500, 2'b01);
        cycle(1'b1, 1'b0, 64'h508, 2'b11);
        cycle(1'b1, 1'b1, 64'h510, 2'b10);
        finish_burst("illegal");
        check("illegal_err0", 64'(err_OUT[0]), 64'd1);
        check("illegal_err2", 64'(err_OUT[2]), 64'd1);
        check("illegal_cnt", 64'(beat_cnt_OUT), 64'd2);

        // backpressure: memory stalled, six read beats into a four-entry FIFO
        ready_mode = 2;
        idle(2);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, (i == 5), 64'h200 + 64'(8 * i), 2'b01);
            if (i == 2) check("bp_ready_3", 64'(ready_OUT), 64'd1);
            if (i == 3) check("bp_ready_full", 64'(ready_OUT), 64'd0);
            if (i == 4) check("bp_err1", 64'(err_OUT[1]), 64'd1);
        end
        check("bp_queued", 64'(exp_q.size()), 64'd4);
        ready_mode = 1;
        finish_burst("bp");
        check("bp_cnt", 64'(beat_cnt_OUT), 64'd4);

        // randomized bursts with random memory stalls
        ready_mode = 0;
        for (int b = 0; b < 30; b++) begin
            len  = $urandom_range(1, 10);
            base = {$urandom, $urandom};
            base[2:0] = 3'b000;
            bt   = 2'($urandom_range(1, 2));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                a = base + 64'(8 * i);
                if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
                t = bt;
                if (i != 0) begin
                    r = $urandom_range(0, 9);
                    if (r == 0) t = 2'b11;
                    else if (r == 1 && i != len - 1) t = 2'b00;
                    else if (r == 2) t = (bt == 2'b01) ? 2'b10 : 2'b01;
                end
                cycle(1'b1, (i == len - 1), a, t);
            end
            finish_burst("rnd");
            idle($urandom_range(0, 2));
        end

        // reset in the middle of a burst
        ready_mode = 2;
        idle(2);
        cycle(1'b1, 1'b0, 64'h300, 2'b10);
        cycle(1'b1, 1'b0, 64'h308, 2'b10);
        reset_L = 1'b0;
        idle(1);
        check_zero("midrst1");
        idle(1);
        check_zero("midrst2");
        reset_L = 1'b1;
        ready_mode = 1;
        idle(2);
        cycle(1'b1, 1'b0, 64'h700, 2'b01);
        check("postrst_cnt_first", 64'(beat_cnt_OUT), 64'd1);
        cycle(1'b1, 1'b0, 64'h708, 2'b01);
        cycle(1'b1, 1'b1, 64'h710, 2'b01);
        finish_burst("postrst");

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
